// File: rtl/apb_completer_regfile_if.sv
// APB bus bundle between a requester (master) and the register-file completer (slave).
interface apb_completer_regfile_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer register file: ID, write counter, CTRL and scratch words,
// with a fixed number of wait states per transfer.
module apb_completer_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  apb_completer_regfile_if.slave    bus,
  output logic [31:0]               ctrl_out
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int SEL_W = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic              pwrite_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wr_count;
  logic [31:0]       regs [2:NUM_REGS-1];

  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  sel;
  logic              err;
  logic              done;
  logic [31:0]       rd_val;

  assign idx  = addr_q[ADDR_W-1:2];
  assign sel  = idx[SEL_W-1:0];
  assign err  = (addr_q[1:0] != 2'b00) || (idx >= IDX_W'(NUM_REGS)) ||
                (pwrite_q && (idx < IDX_W'(2)));
  assign done = (state == ACCESS) && bus.psel && bus.penable && (wcnt == 4'd0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_val = '0;
    if (idx == IDX_W'(0))      rd_val = ID_VALUE;
    else if (idx == IDX_W'(1)) rd_val = wr_count;
    else                       rd_val = regs[sel];
  end

  // Responses depend only on latched transfer state plus the live handshake.
  assign bus.pready  = done;
  assign bus.pslverr = done && err;
  assign bus.prdata  = (done && !err && !pwrite_q) ? rd_val : 32'h0;
  assign ctrl_out    = regs[2];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= 4'd0;
      addr_q   <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      wr_count <= '0;
      // NOTE: the register array is architecturally visible, so it is reset, unlike a plain storage RAM.
      for (int i = 2; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            wcnt     <= 4'(WAIT_CYCLES);
            addr_q   <= bus.paddr;
            pwrite_q <= bus.pwrite;
            wdata_q  <= bus.pwdata;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            if (wcnt != 4'd0) begin
              wcnt <= wcnt - 4'd1;
            end else begin
              state <= IDLE;
              if (pwrite_q && !err) begin
                regs[sel] <= wdata_q;
                wr_count  <= wr_count + 32'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
